// File: rtl/counter_updown_if.sv
// Control and status bundle for counter_updown_mod.
//   master : drives enable/clear/load/load_val/dir/sat_mode/modulo/prescale,
//            observes count/tc/ovf_sticky
//   slave  : the counter itself
interface counter_updown_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             sat_mode;
  logic [WIDTH-1:0] modulo;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf_sticky;

  modport master (
    output enable, clear, load, load_val, dir, sat_mode, modulo, prescale,
    input  count, tc, ovf_sticky
  );

  modport slave (
    input  enable, clear, load, load_val, dir, sat_mode, modulo, prescale,
    output count, tc, ovf_sticky
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable modulo, wrap/saturate mode, synchronous
// clear/load and an enable prescaler.
// Ports:
//   clk    : clock, all state changes on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : counter_updown_if.slave
//            inputs  enable, clear, load, load_val, dir, sat_mode, modulo, prescale
//            outputs count (registered), tc (1-cycle pulse), ovf_sticky
module counter_updown_mod #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_updown_if.slave  bus
);

  logic [WIDTH-1:0] count_p0;
  logic             tc_p0;
  logic             ovf_p0;
  logic [PRE_W-1:0] pre_cnt_p0;

  logic             tick;
  logic [WIDTH:0]   step_res;
  logic [WIDTH-1:0] load_clip;

  // Boundary handling for one tick. Returns {tc, next_count}. The bound
  // comparisons come first so the +1/-1 never leaves the WIDTH-bit range.
  function automatic logic [WIDTH:0] step_f(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] modv,
    input logic             up,
    input logic             sat
  );
    logic [WIDTH:0] r;
    if (up) begin
      if (cur < modv)  r = {1'b0, cur + 1'b1};
      else if (sat)    r = {1'b1, modv};
      else             r = {1'b1, {WIDTH{1'b0}}};
    end else begin
      if (cur == '0)   r = sat ? {1'b1, {WIDTH{1'b0}}} : {1'b1, modv};
      // modulo lowered below the count at runtime: snap down, not a terminal event
      else if (cur > modv) r = {1'b0, modv};
      else             r = {1'b0, cur - 1'b1};
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] clip_f(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] modv
  );
    return (v > modv) ? modv : v;
  endfunction

  assign tick      = bus.enable && (pre_cnt_p0 == bus.prescale);
  assign step_res  = step_f(count_p0, bus.modulo, bus.dir, bus.sat_mode);
  assign load_clip = clip_f(bus.load_val, bus.modulo);

  // Stage p0: counter state, priority clear > load > tick > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p0   <= '0;
      tc_p0      <= 1'b0;
      ovf_p0     <= 1'b0;
      pre_cnt_p0 <= '0;
    end else if (bus.clear) begin
      count_p0   <= '0;
      tc_p0      <= 1'b0;
      ovf_p0     <= 1'b0;
      pre_cnt_p0 <= '0;
    end else if (bus.load) begin
      count_p0   <= load_clip;
      tc_p0      <= 1'b0;
      pre_cnt_p0 <= '0;
    end else begin
      // A prescale lowered below pre_cnt lets pre_cnt run on and wrap
      // naturally through its full range before the next tick.
      if (bus.enable)
        pre_cnt_p0 <= tick ? '0 : pre_cnt_p0 + 1'b1;
      if (tick) begin
        count_p0 <= step_res[WIDTH-1:0];
        tc_p0    <= step_res[WIDTH];
        ovf_p0   <= ovf_p0 | step_res[WIDTH];
      end else begin
        tc_p0    <= 1'b0;
      end
    end
  end

  assign bus.count      = count_p0;
  assign bus.tc         = tc_p0;
  assign bus.ovf_sticky = ovf_p0;

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down counter that replaces the fixed-width free-running up and down counters.
- Adds a runtime direction select, a programmable modulo (terminal value), wrap or saturate mode, synchronous clear and load, and an enable prescaler.
- Emits a terminal-count pulse and a sticky overflow flag for downstream timers, display scanners and cascaded counters.

Parameters:
WIDTH, 8, counter width in bits (≥1)
PRE_W, 4, prescaler width in bits (≥1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  count enable; gates prescaler and counter
clear  in  1  synchronous clear, highest priority after reset
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value loaded when load=1
dir  in  1  1 = count up, 0 = count down
sat_mode  in  1  1 = saturate at bounds, 0 = wrap
modulo  in  WIDTH  terminal value; count range is 0..modulo
prescale  in  PRE_W  counter advances once per (prescale+1) enabled cycles
count  out  WIDTH  current count, registered
tc  out  1  terminal-count pulse, registered, 1 cycle
ovf_sticky  out  1  set by any tc; cleared only by clear or reset

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, tc=0, ovf_sticky=0, internal pre_cnt=0. Takes effect immediately, including mid-prescale or mid-load.
- Priority per edge: clear > load > tick > hold.
- clear=1: count=0, pre_cnt=0, tc=0, ovf_sticky=0. Ignores enable.
- load=1 (clear=0):
  - count = min(load_val, modulo).
  - pre_cnt=0, tc=0, ovf_sticky unchanged.
  - Ignores enable.
- Prescaler:
  - tick = enable & (pre_cnt == prescale).
  - When enable=1: pre_cnt becomes 0 on tick, else pre_cnt+1.
  - When enable=0: pre_cnt holds.
  - prescale=0 gives a tick on every enabled cycle.
- Tick, dir=1:
  - count < modulo: count+1, tc=0.
  - count ≥ modulo, wrap mode: count=0, tc=1.
  - count ≥ modulo, saturate mode: count=modulo, tc=1.
- Tick, dir=0:
  - count == 0, wrap mode: count=modulo, tc=1.
  - count == 0, saturate mode: count=0, tc=1.
  - count > modulo (modulo lowered at runtime): count=modulo, tc=0.
  - Otherwise: count-1, tc=0.
- No tick (and no clear/load): count holds, tc=0.
- tc is asserted in the cycle after the boundary tick edge, together with the new count. It is never high two cycles in a row unless consecutive boundary ticks occur (prescale=0 with saturate mode holding at a bound).
- ovf_sticky <= ovf_sticky | tc_next.
- dir, sat_mode, modulo and prescale are sampled every edge; changing them mid-count takes effect on the next tick with no glitch. Reducing prescale below the current pre_cnt causes the next tick to fire only after pre_cnt wraps through its full range. This behaviour is intended; software clears first.
- modulo = 2^WIDTH-1 with wrap mode reproduces a plain free-running WIDTH-bit up/down counter.
- modulo=0: count stays 0; every tick produces tc=1.
- Arithmetic: unsigned, WIDTH bits. No intermediate overflow is possible because comparisons precede the increment/decrement.
- Latency: one cycle from tick/load/clear to count update.

Test Plan:
1. Reset while running: WIDTH=4, count at 9, assert rst_n=0 between edges → count=0, tc=0, ovf_sticky=0 immediately, without waiting for a clock edge.
2. Wrap up: modulo=9, prescale=0, dir=1, sat=0, enable=1 for 12 cycles → count 1..9,0,1,2. tc=1 exactly in the cycle count shows 0. ovf_sticky=1 thereafter.
3. Saturate down: load_val=2, dir=0, sat=1, 4 ticks → count 1,0,0,0. tc=1 on the 3rd and 4th tick cycles.
4. Prescale: prescale=3, dir=1, enable=1 for 12 cycles → count advances every 4th cycle to 3. Drop enable for 5 cycles → count and pre_cnt frozen, and counting resumes on the correct phase.
5. Priority: clear=1, load=1, load_val=5 in the same cycle → count=0, ovf_sticky=0. Then load=1, load_val=14 with modulo=9 → count=9.
6. Runtime modulo change: count=8, set modulo=5, dir=0 → next tick count=5, tc=0. Set dir=1 → next tick count=0 (wrap), tc=1.
